// File: rtl/prog_loader_if.sv
// Byte-in / program-memory-out bundle of the program loader.
// master: byte source and memory side (the test bench or the top level).
// slave: the loader itself.
interface prog_loader_if #(
    parameter int ADDR_LENGTH        = 11,
    parameter int INSTRUCTION_LENGTH = 16
);
    logic                          i_start;
    logic [7:0]                    i_rx_data;
    logic                          i_rx_valid;
    logic [ADDR_LENGTH-1:0]        o_pm_addr;
    logic [INSTRUCTION_LENGTH-1:0] o_pm_data;
    logic                          o_pm_we;
    logic [ADDR_LENGTH:0]          o_instr_count;
    logic                          o_load_done;
    logic                          o_load_error;
    logic                          o_cpu_run;

    modport master (
        output i_start, i_rx_data, i_rx_valid,
        input  o_pm_addr, o_pm_data, o_pm_we, o_instr_count,
               o_load_done, o_load_error, o_cpu_run
    );

    modport slave (
        input  i_start, i_rx_data, i_rx_valid,
        output o_pm_addr, o_pm_data, o_pm_we, o_instr_count,
               o_load_done, o_load_error, o_cpu_run
    );
endinterface

// File: rtl/prog_loader.sv
// Program loader: assembles MSB-first byte pairs into instruction words,
// writes them to program memory from address 0 and releases the CPU once a
// HALT word has been stored.
// Optional build macro PROG_LOADER_CHECKSUM_EN adds a trailing XOR checksum
// byte that must match before the CPU is released.
module prog_loader #(
    parameter int                       ADDR_LENGTH        = 11,
    parameter int                       INSTRUCTION_LENGTH = 16,
    parameter int                       OPCODE_LENGTH      = 5,
    parameter logic [OPCODE_LENGTH-1:0] HALT_OPCODE        = 5'b00000
) (
    input logic           clk,
    input logic           reset,
    prog_loader_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_HI,
        WAIT_LO,
        WRITE,
`ifdef PROG_LOADER_CHECKSUM_EN
        WAIT_SUM,
`endif
        DONE
    } state_t;

    localparam logic [ADDR_LENGTH-1:0] LAST_ADDR = '1;
    localparam logic [ADDR_LENGTH-1:0] ADDR_ONE  = 1;
    localparam logic [ADDR_LENGTH:0]   COUNT_ONE = 1;

    state_t                        r_state;
    logic [ADDR_LENGTH-1:0]        r_pm_addr;
    logic [INSTRUCTION_LENGTH-1:0] r_pm_data;
    logic                          r_pm_we;
    logic [ADDR_LENGTH:0]          r_instr_count;
    logic                          r_load_done;
    logic                          r_load_error;
    logic                          r_cpu_run;
    logic [7:0]                    r_hi_byte;

    state_t                        w_next_state;
    logic [ADDR_LENGTH-1:0]        w_pm_addr;
    logic [INSTRUCTION_LENGTH-1:0] w_pm_data;
    logic                          w_pm_we;
    logic [ADDR_LENGTH:0]          w_instr_count;
    logic                          w_load_done;
    logic                          w_load_error;
    logic                          w_cpu_run;
    logic [7:0]                    w_hi_byte;
    logic                          w_is_halt;
    logic                          w_is_last;

`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0]                    r_sum;
    logic [7:0]                    w_sum;
`endif

    assign w_is_halt = (r_pm_data[INSTRUCTION_LENGTH-1 -: OPCODE_LENGTH] == HALT_OPCODE);
    assign w_is_last = (r_pm_addr == LAST_ADDR);

    // State and all output registers; reset wins over any in-flight byte.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_pm_addr     <= '0;
            r_pm_data     <= '0;
            r_pm_we       <= 1'b0;
            r_instr_count <= '0;
            r_load_done   <= 1'b0;
            r_load_error  <= 1'b0;
            r_cpu_run     <= 1'b0;
            r_hi_byte     <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
            r_sum         <= '0;
`endif
        end else begin
            r_state       <= w_next_state;
            r_pm_addr     <= w_pm_addr;
            r_pm_data     <= w_pm_data;
            r_pm_we       <= w_pm_we;
            r_instr_count <= w_instr_count;
            r_load_done   <= w_load_done;
            r_load_error  <= w_load_error;
            r_cpu_run     <= w_cpu_run;
            r_hi_byte     <= w_hi_byte;
`ifdef PROG_LOADER_CHECKSUM_EN
            r_sum         <= w_sum;
`endif
        end
    end

    // Next-state selection; start only matters when no load is in progress.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE, DONE: begin
                if (bus.i_start) w_next_state = WAIT_HI;
            end
            WAIT_HI: begin
                if (bus.i_rx_valid) w_next_state = WAIT_LO;
            end
            WAIT_LO: begin
                if (bus.i_rx_valid) w_next_state = WRITE;
            end
            WRITE: begin
                if (w_is_halt) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                    w_next_state = WAIT_SUM;
`else
                    w_next_state = DONE;
`endif
                end else if (w_is_last) begin
                    w_next_state = DONE;
                end else if (bus.i_rx_valid) begin
                    w_next_state = WAIT_LO;
                end else begin
                    w_next_state = WAIT_HI;
                end
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            WAIT_SUM: begin
                if (bus.i_rx_valid) w_next_state = DONE;
            end
`endif
            default: w_next_state = IDLE;
        endcase
    end

    // Next values of the registered outputs; everything holds unless changed.
    always_comb begin
        w_pm_addr     = r_pm_addr;
        w_pm_data     = r_pm_data;
        w_pm_we       = 1'b0;
        w_instr_count = r_instr_count;
        w_load_done   = r_load_done;
        w_load_error  = r_load_error;
        w_cpu_run     = r_cpu_run;
        w_hi_byte     = r_hi_byte;
`ifdef PROG_LOADER_CHECKSUM_EN
        w_sum         = r_sum;
`endif
        case (r_state)
            IDLE, DONE: begin
                if (bus.i_start) begin
                    w_pm_addr     = '0;
                    w_instr_count = '0;
                    w_load_done   = 1'b0;
                    w_load_error  = 1'b0;
                    w_cpu_run     = 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
                    w_sum         = '0;
`endif
                end
            end
            WAIT_HI: begin
                if (bus.i_rx_valid) begin
                    w_hi_byte = bus.i_rx_data;
`ifdef PROG_LOADER_CHECKSUM_EN
                    w_sum     = r_sum ^ bus.i_rx_data;
`endif
                end
            end
            WAIT_LO: begin
                if (bus.i_rx_valid) begin
                    w_pm_data = {r_hi_byte, bus.i_rx_data};
                    w_pm_we   = 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
                    w_sum     = r_sum ^ bus.i_rx_data;
`endif
                end
            end
            WRITE: begin
                w_instr_count = r_instr_count + COUNT_ONE;
                if (w_is_halt) begin
`ifndef PROG_LOADER_CHECKSUM_EN
                    w_load_done = 1'b1;
                    w_cpu_run   = 1'b1;
`endif
                end else if (w_is_last) begin
                    w_load_done  = 1'b1;
                    w_load_error = 1'b1;
                    w_cpu_run    = 1'b0;
                end else begin
                    w_pm_addr = r_pm_addr + ADDR_ONE;
                    if (bus.i_rx_valid) begin
                        w_hi_byte = bus.i_rx_data;
`ifdef PROG_LOADER_CHECKSUM_EN
                        w_sum     = r_sum ^ bus.i_rx_data;
`endif
                    end
                end
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            WAIT_SUM: begin
                if (bus.i_rx_valid) begin
                    w_load_done = 1'b1;
                    if (bus.i_rx_data == r_sum) begin
                        w_cpu_run = 1'b1;
                    end else begin
                        w_load_error = 1'b1;
                    end
                end
            end
`endif
            default: begin
                w_pm_we = 1'b0;
            end
        endcase
    end

    assign bus.o_pm_addr     = r_pm_addr;
    assign bus.o_pm_data     = r_pm_data;
    assign bus.o_pm_we       = r_pm_we;
    assign bus.o_instr_count = r_instr_count;
    assign bus.o_load_done   = r_load_done;
    assign bus.o_load_error  = r_load_error;
    assign bus.o_cpu_run     = r_cpu_run;

endmodule
